// File: rtl/dvp_capture_ctrl.sv
// DVP frame-capture sequencer: qualifies VSYNC/HREF on PCLK strobes and packs byte pairs into RGB565 FIFO writes.
// Optional frame statistics outputs (frame_cnt_o, drop_cnt_o) are built when DVP_FRAME_STATS_EN is defined.
module dvp_capture_ctrl #(
    parameter int   H_PIX     = 640,
    parameter int   V_LINE    = 480,
    parameter logic VSYNC_ACT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap_start_i,
    input  logic        cap_stop_i,
    input  logic        cap_cont_i,
    input  logic        pclk_sync_i,
    input  logic        dvp_vsync_i,
    input  logic        dvp_href_i,
    input  logic [7:0]  dvp_d_i,
    input  logic        pf_full_i,
    output logic        pf_wr_en_o,
    output logic [15:0] pf_wr_data_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        frame_err_o,
    output logic [9:0]  line_cnt_o,
    output logic [10:0] pix_cnt_o
`ifdef DVP_FRAME_STATS_EN
    ,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] drop_cnt_o
`endif
);

    localparam logic [10:0] H_PIX_W  = 11'(H_PIX);
    localparam logic [9:0]  V_LINE_W = 10'(V_LINE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_CAPTURE,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic        cont_q, cont_d;
    logic        stop_pend_q, stop_pend_d;
    logic        seen_vs_q, seen_vs_d;
    logic        phase_q, phase_d;
    logic        href_prev_q, href_prev_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] pix_q, pix_d;
    logic        wr_pend_q, wr_pend_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic [10:0] pix_cnt_q, pix_cnt_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic        vs_act;
    logic        wr_fire;
    logic        wr_ovf;
    logic        line_end;
    logic        resume;
    logic [10:0] pix_next;
    logic [9:0]  line_next;

    // FIFO handshake: pf_wr_en_o is the valid and !pf_full_i the ready. A pixel
    // transfers only in the cycle after its second byte, and only if the FIFO is
    // not full then; a pending pixel that meets full is discarded, never retried.
    assign vs_act    = (dvp_vsync_i == VSYNC_ACT);
    assign wr_fire   = (state_q == S_CAPTURE) && wr_pend_q && !pf_full_i;
    assign wr_ovf    = (state_q == S_CAPTURE) && wr_pend_q && pf_full_i;
    assign line_end  = (state_q == S_CAPTURE) && pclk_sync_i && href_prev_q && !dvp_href_i;
    assign pix_next  = (wr_fire && pix_cnt_q != '1) ? pix_cnt_q + 11'd1 : pix_cnt_q;
    assign line_next = (line_end && line_cnt_q != '1) ? line_cnt_q + 10'd1 : line_cnt_q;
    assign resume    = cont_q && !stop_pend_q && !cap_stop_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            seen_vs_q   <= 1'b0;
            phase_q     <= 1'b0;
            href_prev_q <= 1'b0;
            hi_q        <= '0;
            pix_q       <= '0;
            wr_pend_q   <= 1'b0;
            line_cnt_q  <= '0;
            pix_cnt_q   <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            seen_vs_q   <= seen_vs_d;
            phase_q     <= phase_d;
            href_prev_q <= href_prev_d;
            hi_q        <= hi_d;
            pix_q       <= pix_d;
            wr_pend_q   <= wr_pend_d;
            line_cnt_q  <= line_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cont_d      = cont_q;
        stop_pend_d = stop_pend_q;
        seen_vs_d   = seen_vs_q;
        phase_d     = phase_q;
        href_prev_d = href_prev_q;
        hi_d        = hi_q;
        pix_d       = pix_q;
        wr_pend_d   = 1'b0;
        line_cnt_d  = line_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (cap_start_i) begin
                    cont_d      = cap_cont_i;
                    err_d       = 1'b0;
                    stop_pend_d = cap_stop_i;
                    seen_vs_d   = 1'b0;
                    state_d     = S_WAIT_VS;
                end
            end

            S_WAIT_VS: begin
                if (cap_stop_i) begin
                    state_d = S_IDLE;
                end else if (pclk_sync_i) begin
                    if (vs_act) begin
                        seen_vs_d = 1'b1;
                    end else if (seen_vs_q) begin
                        line_cnt_d  = '0;
                        pix_cnt_d   = '0;
                        phase_d     = 1'b0;
                        href_prev_d = 1'b0;
                        state_d     = S_CAPTURE;
                    end
                end
            end

            S_CAPTURE: begin
                pix_cnt_d = pix_next;
                if (cap_stop_i) stop_pend_d = 1'b1;
                if (wr_ovf) begin
                    err_d   = 1'b1;
                    state_d = S_DROP;
                end
                if (pclk_sync_i) begin
                    href_prev_d = dvp_href_i;
                    // Line end is resolved before frame end so a coincident VSYNC sees the final line count.
                    if (line_end) begin
                        line_cnt_d = line_next;
                        pix_cnt_d  = '0;
                        phase_d    = 1'b0;
                        if (pix_next != H_PIX_W || phase_q) err_d = 1'b1;
                    end
                    if (vs_act) begin
                        done_d    = 1'b1;
                        seen_vs_d = 1'b1;
                        if (line_next != V_LINE_W) err_d = 1'b1;
                        state_d   = resume ? S_WAIT_VS : S_IDLE;
                    end else if (dvp_href_i) begin
                        if (!phase_q) begin
                            hi_d    = dvp_d_i;
                            phase_d = 1'b1;
                        end else begin
                            pix_d     = {hi_q, dvp_d_i};
                            wr_pend_d = 1'b1;
                            phase_d   = 1'b0;
                        end
                    end
                end
            end

            S_DROP: begin
                if (cap_stop_i) stop_pend_d = 1'b1;
                if (pclk_sync_i && vs_act) begin
                    done_d    = 1'b1;
                    seen_vs_d = 1'b1;
                    state_d   = resume ? S_WAIT_VS : S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

`ifdef DVP_FRAME_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (done_d) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (state_q == S_DROP) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`endif

    assign pf_wr_en_o   = wr_fire;
    assign pf_wr_data_o = pix_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = done_q;
    assign frame_err_o  = err_q;
    assign line_cnt_o   = line_cnt_q;
    assign pix_cnt_o    = pix_cnt_q;

endmodule
